// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM states and op decode for alu_seq
// Divider support follows the ALU_DIV_EN macro.
package alu_seq_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_NOR   = 4'b0100;
   localparam logic [3:0] OP_SLTU  = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;
   localparam logic [3:0] OP_DIV   = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b1011;
   localparam logic [3:0] OP_MFHI  = 4'b1100;
   localparam logic [3:0] OP_MFLO  = 4'b1101;

`ifdef ALU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   function automatic logic op_is_mul(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic op_is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// rtl/alu_seq_muldiv_iter.sv - shift-add multiplier / restoring divider on one 2*WIDTH accumulator
// Divider datapath present only with ALU_DIV_EN defined.
module alu_seq_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               div_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   bop;
   logic [CW-1:0]      count;
   logic               busy;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   // Multiplier keeps {partial product, unconsumed multiplier bits} and shifts right.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, bop};
      mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
   end

`ifdef ALU_DIV_EN
   logic               mode;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] div_next;

   // Divider keeps {remainder, dividend/quotient} and shifts left; a borrow restores.
   always_comb begin
      div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, bop};
      div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      result    = mode ? div_next : mul_next;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mode <= 1'b0;
      end else if (start) begin
         mode <= div_mode;
      end
   end
`else
   logic unused_div_mode;
   assign unused_div_mode = div_mode;
   assign result          = mul_next;
`endif

   assign done = busy && (count == LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc   <= '0;
         bop   <= '0;
         count <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         acc   <= {{WIDTH{1'b0}}, a};
         bop   <= b;
         count <= '0;
         busy  <= 1'b1;
      end else if (busy) begin
         acc   <= result;
         count <= done ? '0 : count + 1'b1;
         busy  <= !done;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked EX-stage ALU with iterative mult/div and HI/LO
// Defining ALU_DIV_EN adds DIV/DIVU; otherwise they behave as undefined codes.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       aluop,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t             state_q, state_d;
   logic               accept, mul_sel, div_sel, is_iter, op_signed;
   logic               iter_start, iter_done;
   logic [WIDTH-1:0]   mag1, mag2, sum, diff, sc_result;
   logic               sc_ovf, neg_lo_q;
   logic [2*WIDTH-1:0] iter_result, prod_fix;
   logic [WIDTH-1:0]   hi_new, lo_new;

   assign in_ready  = reset_n && (state_q == ST_IDLE) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_sel   = op_is_mul(aluop);
   assign div_sel   = DIV_EN && op_is_div(aluop);
   assign is_iter   = mul_sel || div_sel;
   assign op_signed = !aluop[0];
   assign zero      = (out == '0);

   // The iterator works on magnitudes; signs are reapplied on completion.
   assign mag1 = (op_signed && in1[WIDTH-1]) ? -in1 : in1;
   assign mag2 = (op_signed && in2[WIDTH-1]) ? -in2 : in2;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      iter_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept && is_iter) begin
               iter_start = 1'b1;
               state_d    = div_sel ? ST_DIV : ST_MUL;
            end
         end
         ST_MUL, ST_DIV: begin
            if (iter_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   alu_seq_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (iter_start),
      .div_mode (div_sel),
      .a        (mag1),
      .b        (mag2),
      .done     (iter_done),
      .result   (iter_result)
   );

   always_comb begin
      sum       = in1 + in2;
      diff      = in1 - in2;
      sc_result = '0;
      sc_ovf    = 1'b0;
      case (aluop)
         OP_AND:  sc_result = in1 & in2;
         OP_OR:   sc_result = in1 | in2;
         OP_XOR:  sc_result = in1 ^ in2;
         OP_NOR:  sc_result = ~(in1 | in2);
         OP_ADD: begin
            sc_result = sum;
            sc_ovf    = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
         end
         OP_SUB: begin
            sc_result = diff;
            sc_ovf    = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
         end
         OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
         OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (in1 < in2)};
         OP_MFHI: sc_result = hi;
         OP_MFLO: sc_result = lo;
         default: sc_result = '0;
      endcase
   end

`ifdef ALU_DIV_EN
   logic             neg_hi_q, dz_q;
   logic [WIDTH-1:0] in1_q, quo, rem;

   assign quo = iter_result[WIDTH-1:0];
   assign rem = iter_result[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         neg_hi_q <= 1'b0;
         dz_q     <= 1'b0;
         in1_q    <= '0;
      end else if (accept && is_iter) begin
         neg_hi_q <= op_signed && in1[WIDTH-1];
         dz_q     <= (in2 == '0);
         in1_q    <= in1;
      end
   end
`endif

   always_comb begin
      prod_fix = neg_lo_q ? -iter_result : iter_result;
      hi_new   = prod_fix[2*WIDTH-1:WIDTH];
      lo_new   = prod_fix[WIDTH-1:0];
`ifdef ALU_DIV_EN
      if (state_q == ST_DIV) begin
         if (dz_q) begin
            lo_new = '1;
            hi_new = in1_q;
         end else begin
            lo_new = neg_lo_q ? -quo : quo;
            hi_new = neg_hi_q ? -rem : rem;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out       <= '0;
         overflow  <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         neg_lo_q  <= 1'b0;
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (accept) begin
            if (is_iter) begin
               neg_lo_q <= op_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
            end else begin
               out       <= sc_result;
               overflow  <= sc_ovf;
               out_valid <= 1'b1;
            end
         end
         if (iter_done) begin
            hi        <= hi_new;
            lo        <= lo_new;
            out       <= lo_new;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (DIV tests follow ALU_DIV_EN)
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  aluop = 4'b0000;
   logic [31:0] in1 = '0;
   logic [31:0] in2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out;
   logic        zero;
   logic        overflow;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int failures = 0;

   alu_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .aluop     (aluop),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero      (zero),
      .overflow  (overflow),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      aluop    = op;
      in1      = a;
      in2      = b;
      step();
      in_valid = 1'b0;
   endtask

   // Waits for out_valid after an iterative accept; edges counted from the accept edge.
   task automatic wait_result(output int edges, output int rdy_low);
      edges   = 0;
      rdy_low = 0;
      while (out_valid !== 1'b1 && edges < 100) begin
         if (in_ready === 1'b0) rdy_low++;
         step();
         edges++;
      end
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      out_ready = 1'b1;
      repeat (2) step();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (out !== 32'h0) begin failures++; $display("FAIL rst_out: got %h want 0", out); end
      checks++; if (zero !== 1'b1) begin failures++; $display("FAIL rst_zero: got %b want 1", zero); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow: got %b want 0", overflow); end
      checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL rst_hilo: got %h want 0", {hi, lo}); end
      reset_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add_overflow();
      out_ready = 1'b1;
      issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid: got %b want 1", out_valid); end
      checks++; if (out !== 32'h8000_0000) begin failures++; $display("FAIL add_out: got %h want 80000000", out); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL add_ovf: got %b want 1", overflow); end
      checks++; if (zero !== 1'b0) begin failures++; $display("FAIL add_zero: got %b want 0", zero); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drop: got %b want 0", out_valid); end
   endtask

   task automatic test_single_ops();
      logic [3:0]  op_t  [11] = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b0101,
                                  4'b0110, 4'b0010, 4'b1110, 4'b0110, 4'b0010};
      logic [31:0] a_t   [11] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678, 32'h0F0F0000, 32'hFFFFFFFF,
                                  32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h00000005, 32'h7FFFFFFF,
                                  32'h80000000};
      logic [31:0] b_t   [11] = '{32'h0FF00FF0, 32'h0FF00FF0, 32'hFFFF0000, 32'h00F0000F, 32'h00000001,
                                  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000005, 32'hFFFFFFFF,
                                  32'h80000000};
      logic [31:0] exp_t [11] = '{32'h00F000F0, 32'hFFF0FFF0, 32'hEDCB5678, 32'hF000FFF0, 32'h00000000,
                                  32'h00000001, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h80000000,
                                  32'h00000000};
      logic        ovf_t [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         in_valid = 1'b1;
         aluop    = op_t[i];
         in1      = a_t[i];
         in2      = b_t[i];
         #1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ops_ready[%0d]: got %b want 1", i, in_ready); end
         step();
         checks++; if (out !== exp_t[i]) begin failures++; $display("FAIL ops_out[%0d]: got %h want %h", i, out, exp_t[i]); end
         checks++; if (overflow !== ovf_t[i]) begin failures++; $display("FAIL ops_ovf[%0d]: got %b want %b", i, overflow, ovf_t[i]); end
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ops_valid[%0d]: got %b want 1", i, out_valid); end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      aluop     = 4'b0110;
      in1       = 32'd5;
      in2       = 32'd5;
      step();
      checks++; if (out !== 32'h0 || zero !== 1'b1) begin failures++; $display("FAIL b2b_sub: got out=%h zero=%b want 0/1", out, zero); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
      aluop = 4'b0111;
      in1   = 32'hFFFF_FFFF;
      in2   = 32'd1;
      step();
      in_valid = 1'b0;
      checks++; if (out !== 32'h1 || zero !== 1'b0) begin failures++; $display("FAIL b2b_slt: got out=%h zero=%b want 1/0", out, zero); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
      step();
   endtask

   task automatic test_mult();
      int edges, rdy_low;
      out_ready = 1'b1;
      issue(4'b1000, 32'hFFFF_FFFD, 32'd7);
      in1   = 32'hDEAD_BEEF;
      in2   = 32'h1234_5678;
      aluop = 4'b0000;
      wait_result(edges, rdy_low);
      checks++; if (edges != 32) begin failures++; $display("FAIL mult_latency: got %0d edges want 32", edges); end
      checks++; if (rdy_low != 32) begin failures++; $display("FAIL mult_busy: got %0d low cycles want 32", rdy_low); end
      checks++; if (lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
      checks++; if (out !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_out: got %h want ffffffeb", out); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mult_ready_after: got %b want 1", in_ready); end
      issue(4'b1100, 32'h0, 32'h0);
      checks++; if (out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mfhi: got %h want ffffffff", out); end
      issue(4'b1101, 32'h0, 32'h0);
      checks++; if (out !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mflo: got %h want ffffffeb", out); end
      step();
      issue(4'b1000, 32'h8000_0000, 32'h8000_0000);
      wait_result(edges, rdy_low);
      checks++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin failures++; $display("FAIL mult_min: got %h want 4000000000000000", {hi, lo}); end
      checks++; if (zero !== 1'b1) begin failures++; $display("FAIL mult_min_zero: got %b want 1", zero); end
      step();
      issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_result(edges, rdy_low);
      checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL multu: got %h want fffffffe00000001", {hi, lo}); end
      step();
   endtask

`ifdef ALU_DIV_EN
   task automatic test_div();
      int          edges, rdy_low;
      logic [3:0]  op_t [5] = '{4'b1010, 4'b1011, 4'b1010, 4'b1010, 4'b1011};
      logic [31:0] a_t  [5] = '{32'hFFFFFFF9, 32'd9, 32'h80000000, 32'd7, 32'd100};
      logic [31:0] b_t  [5] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd7};
      logic [31:0] lo_t [5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'd14};
      logic [31:0] hi_t [5] = '{32'hFFFFFFFF, 32'd9, 32'h00000000, 32'd1, 32'd2};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         issue(op_t[i], a_t[i], b_t[i]);
         wait_result(edges, rdy_low);
         checks++; if (edges != 32) begin failures++; $display("FAIL div_latency[%0d]: got %0d want 32", i, edges); end
         checks++; if (lo !== lo_t[i] || out !== lo_t[i]) begin failures++; $display("FAIL div_lo[%0d]: got lo=%h out=%h want %h", i, lo, out, lo_t[i]); end
         checks++; if (hi !== hi_t[i]) begin failures++; $display("FAIL div_hi[%0d]: got %h want %h", i, hi, hi_t[i]); end
         step();
      end
   endtask
`else
   task automatic test_div_disabled();
      out_ready = 1'b1;
      issue(4'b1011, 32'd9, 32'd0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL nodiv_valid: got %b want 1", out_valid); end
      checks++; if (out !== 32'h0) begin failures++; $display("FAIL nodiv_out: got %h want 0", out); end
      checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL nodiv_hilo: got %h want fffffffe00000001", {hi, lo}); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL nodiv_ready: got %b want 1", in_ready); end
      issue(4'b1010, 32'hFFFF_FFF9, 32'd2);
      checks++; if (out !== 32'h0 || lo !== 32'h0000_0001) begin failures++; $display("FAIL nodiv_signed: got out=%h lo=%h want 0/1", out, lo); end
      step();
   endtask
`endif

   task automatic test_stall();
      out_ready = 1'b0;
      issue(4'b0010, 32'd3, 32'd4);
      in_valid = 1'b1;
      aluop    = 4'b0001;
      in1      = 32'd1;
      in2      = 32'd2;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (out !== 32'd7 || out_valid !== 1'b1 || zero !== 1'b0) begin failures++; $display("FAIL stall_hold[%0d]: got out=%h valid=%b want 7/1", i, out, out_valid); end
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready); end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release: got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (out !== 32'd3 || out_valid !== 1'b1) begin failures++; $display("FAIL stall_take_accept: got out=%h valid=%b want 3/1", out, out_valid); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_drop: got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_mult();
      int seen = 0;
      out_ready = 1'b1;
      issue(4'b1000, 32'd5, 32'd6);
      repeat (9) step();
      reset_n = 1'b0;
      step();
      checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL midrst_hilo: got %h want 0", {hi, lo}); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready_low: got %b want 0", in_ready); end
      reset_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready_release: got %b want 1", in_ready); end
      for (int i = 0; i < 40; i++) begin
         step();
         if (out_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_result: got %0d valid cycles want 0", seen); end
      checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL midrst_hilo_after: got %h want 0", {hi, lo}); end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_single_ops();
      test_back_to_back();
      test_mult();
`ifdef ALU_DIV_EN
      test_div();
`else
      test_div_disabled();
`endif
      test_stall();
      test_reset_mid_mult();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
